clock_period_meter: RTL and testbench
=====================================

// Module: clock_period_meter
// PURPOSE
//  Measures a divided/slow clock sampled in the clock_in domain: period and high
//  time in clock_in cycles, plus lock and loss-of-clock status. Check/receive side
//  of the clock divider chain; reports the effective divisor and duty for self-test.
// PARAMETERS
//  CNT_WIDTH    28          width of period/high-time counters and outputs
//  SYNC_STAGES  2           synchronizer flops on clk_sense (>=2)
//  LOCK_COUNT   4           consecutive matching measurements needed for lock (>=2)
//  TOLERANCE    0           max |period - previous period| counted as a match
//  TIMEOUT      28'd1000000 cycles without a rise -> loss of clock (< 2^CNT_WIDTH-1)
// PORTS
//  clock_in   in   1          sole clock; all logic on posedge
//  reset      in   1          synchronous, active-high reset
//  clk_sense  in   1          signal under measurement; asynchronous, synchronized here
//  period     out  CNT_WIDTH  last measured rise-to-rise period, clock_in cycles
//  high_time  out  CNT_WIDTH  cycles sample was high within that period
//  valid      out  1          1-cycle pulse when period/high_time update
//  locked     out  1          LOCK_COUNT consecutive measurements within TOLERANCE
//  timeout    out  1          level; no rise for TIMEOUT cycles
// BEHAVIOUR
//  - Reset (sync, active-high): synchronizer, edge reg, counters clear; state IDLE;
//    period=0, high_time=0, valid=0, locked=0, timeout=0. Reset mid-period discards it.
//  - Rise = synced sample 1 and previous sample 0. Input must be < clock_in/2.
//  - per_cnt: on rise <=1, else +1, saturating at TIMEOUT. Cleared by reset.
//  - high_cnt: on rise <=1, else += synced sample.
//  - States: IDLE (unarmed) -> MEASURE on first rise (arming rise: no valid, clears
//    timeout). In MEASURE each rise: period<=per_cnt, high_time<=high_cnt, valid=1.
//  - Latency: clk_sense rising edge -> valid pulse: SYNC_STAGES+1 cycles.
//  - Lock: on each valid, match = |per_cnt - period| <= TOLERANCE; match_run +1 if
//    match else 1. locked=1 in the valid cycle where match_run reaches LOCK_COUNT;
//    mismatch drops locked in that valid cycle. Lock holds between valids.
//  - Timeout: per_cnt==TIMEOUT with no rise this cycle -> timeout=1, locked=0,
//    match_run=0, state IDLE, no valid; period/high_time retained. Applies in IDLE too
//    (no first rise within TIMEOUT after reset). Rise in same cycle wins over timeout.
//  - valid never asserts two consecutive cycles (minimum period 2).
//  - Outputs registered; period/high_time change only in valid cycles.
// TESTING
//  1. Toggle clk_sense every cycle (divisor 2) -> after arming, valid every 2 cycles,
//     period=2, high_time=1; locked on 4th valid.
//  2. Low 5/high 5 pattern (divisor 10) -> period=10, high_time=5, locked after 4 valids;
//     first valid exactly SYNC_STAGES+1 cycles after second clk_sense rise.
//  3. High 3/low 7 pattern -> period=10, high_time=3; duty independent of phase at reset.
//  4. Locked at 10, switch to period 12 -> first valid period=12, locked drops same
//     cycle; relocks on 4th consecutive 12 (TOLERANCE=0); with TOLERANCE=2 stays locked.
//  5. TIMEOUT=50, stop clk_sense high -> timeout=1 and locked=0 exactly 50 cycles after
//     last rise reload; restart -> first rise clears timeout, no valid; second rise valid.
//  6. Assert reset mid-period while locked -> next cycle all outputs 0; first post-reset
//     rise gives no valid; valid only from second rise.

Source files
------------

// File: rtl/clock_period_meter.sv
// Measures rise-to-rise period and high time of clk_sense in clock_in cycles, with lock and loss-of-clock status.
// valid pulses SYNC_STAGES+1 cycles after a clk_sense rise; no backpressure, results are overwritten by the next valid.
module clock_period_meter #(
    parameter int                   CNT_WIDTH   = 28,
    parameter int                   SYNC_STAGES = 2,
    parameter int                   LOCK_COUNT  = 4,
    parameter int                   TOLERANCE   = 0,
    parameter logic [CNT_WIDTH-1:0] TIMEOUT     = CNT_WIDTH'(1000000)
) (
    input  logic                 clock_in,
    input  logic                 reset,
    input  logic                 clk_sense,
    output logic [CNT_WIDTH-1:0] period,
    output logic [CNT_WIDTH-1:0] high_time,
    output logic                 valid,
    output logic                 locked,
    output logic                 timeout
);

    localparam int RUN_W = $clog2(LOCK_COUNT + 1);

    typedef enum logic {
        IDLE,
        MEASURE
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q;
    logic [CNT_WIDTH-1:0]   per_cnt_q, per_cnt_d;
    logic [CNT_WIDTH-1:0]   high_cnt_q, high_cnt_d;
    logic [CNT_WIDTH-1:0]   period_q, period_d;
    logic [CNT_WIDTH-1:0]   high_q, high_d;
    logic [RUN_W-1:0]       run_q, run_d;
    logic                   valid_q, valid_d;
    logic                   locked_q, locked_d;
    logic                   timeout_q, timeout_d;

    logic                   sample;
    logic                   rise;
    logic                   expired;
    logic                   match;
    logic [CNT_WIDTH-1:0]   diff;

    assign sync_d  = {sync_q[SYNC_STAGES-2:0], clk_sense};
    assign sample  = sync_q[SYNC_STAGES-1];
    assign rise    = sample & ~prev_q;
    assign expired = (per_cnt_q == TIMEOUT) && !rise;
    assign diff    = (per_cnt_q >= period_q) ? (per_cnt_q - period_q) : (period_q - per_cnt_q);
    assign match   = diff <= CNT_WIDTH'(TOLERANCE);

    always_comb begin
        state_d    = state_q;
        period_d   = period_q;
        high_d     = high_q;
        run_d      = run_q;
        valid_d    = 1'b0;
        locked_d   = locked_q;
        timeout_d  = timeout_q;
        per_cnt_d  = per_cnt_q;
        high_cnt_d = high_cnt_q;

        // Both counters saturate so a stalled input cannot wrap them back into range.
        if (rise) begin
            per_cnt_d  = CNT_WIDTH'(1);
            high_cnt_d = CNT_WIDTH'(1);
        end else begin
            if (per_cnt_q != TIMEOUT) per_cnt_d = per_cnt_q + CNT_WIDTH'(1);
            if (high_cnt_q != TIMEOUT) high_cnt_d = high_cnt_q + CNT_WIDTH'(sample);
        end

        if (rise) begin
            case (state_q)
                IDLE: begin
                    state_d   = MEASURE;
                    timeout_d = 1'b0;
                end
                MEASURE: begin
                    valid_d  = 1'b1;
                    period_d = per_cnt_q;
                    high_d   = high_cnt_q;
                    if (!match) run_d = RUN_W'(1);
                    else if (run_q < RUN_W'(LOCK_COUNT)) run_d = run_q + RUN_W'(1);
                    locked_d = (run_d == RUN_W'(LOCK_COUNT));
                end
                default: state_d = IDLE;
            endcase
        end else if (expired) begin
            state_d   = IDLE;
            timeout_d = 1'b1;
            locked_d  = 1'b0;
            run_d     = '0;
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_q    <= IDLE;
            sync_q     <= '0;
            prev_q     <= 1'b0;
            per_cnt_q  <= '0;
            high_cnt_q <= '0;
            period_q   <= '0;
            high_q     <= '0;
            run_q      <= '0;
            valid_q    <= 1'b0;
            locked_q   <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            prev_q     <= sample;
            per_cnt_q  <= per_cnt_d;
            high_cnt_q <= high_cnt_d;
            period_q   <= period_d;
            high_q     <= high_d;
            run_q      <= run_d;
            valid_q    <= valid_d;
            locked_q   <= locked_d;
            timeout_q  <= timeout_d;
        end
    end

    assign period    = period_q;
    assign high_time = high_q;
    assign valid     = valid_q;
    assign locked    = locked_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_clock_period_meter.sv
// Bench for clock_period_meter: a stimulus-side model queues expected measurements at each
// driven rise; a monitor pops and compares them whenever valid pulses.
module tb_clock_period_meter;

    localparam int CW  = 16;
    localparam int TMO = 50;
    localparam int LC  = 4;

    logic          clock_in = 1'b0;
    logic          reset;
    logic          clk_sense;
    logic [CW-1:0] period, high_time, period2, high_time2;
    logic          valid, locked, timeout, valid2, locked2, timeout2;

    clock_period_meter #(
        .CNT_WIDTH(CW), .SYNC_STAGES(2), .LOCK_COUNT(LC), .TOLERANCE(0), .TIMEOUT(CW'(TMO))
    ) dut (
        .clock_in(clock_in), .reset(reset), .clk_sense(clk_sense),
        .period(period), .high_time(high_time), .valid(valid),
        .locked(locked), .timeout(timeout)
    );

    clock_period_meter #(
        .CNT_WIDTH(CW), .SYNC_STAGES(2), .LOCK_COUNT(LC), .TOLERANCE(2), .TIMEOUT(CW'(TMO))
    ) dut2 (
        .clock_in(clock_in), .reset(reset), .clk_sense(clk_sense),
        .period(period2), .high_time(high_time2), .valid(valid2),
        .locked(locked2), .timeout(timeout2)
    );

    always #5 clock_in = ~clock_in;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clock_in) cyc <= cyc + 1;

    typedef struct {
        int per;
        int hi;
        bit lk;
    } exp_t;

    exp_t sb[$];

    bit armed;
    bit prev_v;
    int last_rise;
    int hi_acc;
    int m_period;
    int run;

    function automatic void model_reset();
        armed     = 1'b0;
        prev_v    = 1'b0;
        run       = 0;
        m_period  = 0;
        hi_acc    = 0;
        last_rise = cyc;
    endfunction

    // One clk_sense sample per clock_in cycle; expected results are queued when a rise is driven.
    task automatic drive_cycle(input bit v);
        exp_t e;
        int   per;
        int   d;
        @(negedge clock_in);
        clk_sense = v;
        if (v && !prev_v) begin
            if (armed) begin
                per = cyc - last_rise;
                d   = (per > m_period) ? per - m_period : m_period - per;
                run = (d == 0) ? ((run < LC) ? run + 1 : LC) : 1;
                e.per = per;
                e.hi  = hi_acc;
                e.lk  = (run >= LC);
                sb.push_back(e);
                m_period = per;
            end
            armed     = 1'b1;
            last_rise = cyc;
            hi_acc    = 1;
        end else begin
            hi_acc += int'(v);
            if (cyc - last_rise >= TMO) begin
                armed = 1'b0;
                run   = 0;
            end
        end
        prev_v = v;
    endtask

    task automatic wave(input int hi, input int lo, input int n);
        for (int i = 0; i < n; i++) begin
            repeat (hi) drive_cycle(1'b1);
            repeat (lo) drive_cycle(1'b0);
        end
    endtask

    task automatic do_reset();
        @(negedge clock_in);
        reset     = 1'b1;
        clk_sense = 1'b0;
        repeat (2) @(negedge clock_in);
        reset = 1'b0;
        model_reset();
    endtask

    always @(negedge clock_in) begin
        exp_t e;
        if (valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid cycle %0d: period %0d high_time %0d, no measurement expected",
                         cyc, period, high_time);
            end else begin
                e = sb.pop_front();
                if (period !== CW'(e.per) || high_time !== CW'(e.hi) || locked !== e.lk) begin
                    errors++;
                    $display("FAIL measurement cycle %0d: got period %0d high_time %0d locked %0b, want %0d %0d %0b",
                             cyc, period, high_time, locked, e.per, e.hi, e.lk);
                end
            end
        end
    end

    task automatic test_reset();
        reset     = 1'b1;
        clk_sense = 1'b0;
        repeat (3) @(negedge clock_in);
        checks++;
        if ({period, high_time, valid, locked, timeout} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got period %0d high_time %0d valid %0b locked %0b timeout %0b, want all 0",
                     period, high_time, valid, locked, timeout);
        end
        checks++;
        if ({period2, high_time2, valid2, locked2, timeout2} !== '0) begin
            errors++;
            $display("FAIL reset_outputs_tol2: got period %0d high_time %0d valid %0b locked %0b timeout %0b, want all 0",
                     period2, high_time2, valid2, locked2, timeout2);
        end
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_div2();
        repeat (12) begin
            drive_cycle(1'b1);
            drive_cycle(1'b0);
        end
        repeat (4) drive_cycle(1'b0);
        checks++;
        if (period !== CW'(2) || high_time !== CW'(1) || locked !== 1'b1) begin
            errors++;
            $display("FAIL div2_final: got period %0d high_time %0d locked %0b, want 2 1 1", period, high_time, locked);
        end
    endtask

    task automatic test_div10();
        do_reset();
        repeat (5) drive_cycle(1'b0);
        repeat (5) drive_cycle(1'b1);
        repeat (5) drive_cycle(1'b0);
        drive_cycle(1'b1);
        for (int k = 1; k <= 4; k++) begin
            drive_cycle(1'b1);
            if (k <= 3) begin
                checks++;
                if (valid !== (k == 3)) begin
                    errors++;
                    $display("FAIL first_valid_latency: %0d cycles after rise valid %0b, want %0b", k, valid, (k == 3));
                end
            end
        end
        repeat (5) drive_cycle(1'b0);
        wave(5, 5, 6);
        checks++;
        if (locked !== 1'b1 || period !== CW'(10) || high_time !== CW'(5)) begin
            errors++;
            $display("FAIL div10_final: got locked %0b period %0d high_time %0d, want 1 10 5", locked, period, high_time);
        end
    endtask

    task automatic test_duty();
        do_reset();
        wave(3, 7, 6);
        checks++;
        if (period !== CW'(10) || high_time !== CW'(3)) begin
            errors++;
            $display("FAIL duty_3_7: got period %0d high_time %0d, want 10 3", period, high_time);
        end
    endtask

    task automatic test_period_change();
        bit tol_held;
        wave(5, 5, 5);
        checks++;
        if (locked !== 1'b1 || locked2 !== 1'b1) begin
            errors++;
            $display("FAIL lock_before_change: got locked %0b locked_tol2 %0b, want 1 1", locked, locked2);
        end
        tol_held = 1'b1;
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 12; j++) begin
                drive_cycle(j < 6);
                if (locked2 !== 1'b1) tol_held = 1'b0;
            end
        end
        checks++;
        if (tol_held !== 1'b1 || period2 !== CW'(12)) begin
            errors++;
            $display("FAIL tol2_stays_locked: got held %0b period %0d, want 1 12", tol_held, period2);
        end
    endtask

    task automatic test_timeout();
        bit found;
        drive_cycle(1'b1);
        found = 1'b0;
        for (int k = 0; k < 6 && !found; k++) begin
            drive_cycle(1'b1);
            if (valid === 1'b1) found = 1'b1;
        end
        checks++;
        if (found !== 1'b1 || locked !== 1'b1) begin
            errors++;
            $display("FAIL last_valid_before_stop: got seen %0b locked %0b, want 1 1", found, locked);
        end
        for (int i = 1; i <= TMO; i++) begin
            drive_cycle(1'b1);
            if (i == TMO - 1) begin
                checks++;
                if (timeout !== 1'b0) begin
                    errors++;
                    $display("FAIL timeout_early: %0d cycles after reload timeout %0b, want 0", i, timeout);
                end
            end
        end
        checks++;
        if (timeout !== 1'b1 || locked !== 1'b0 || period !== CW'(12) || high_time !== CW'(6)) begin
            errors++;
            $display("FAIL timeout_assert: got timeout %0b locked %0b period %0d high_time %0d, want 1 0 12 6",
                     timeout, locked, period, high_time);
        end
        repeat (4) drive_cycle(1'b0);
        repeat (6) drive_cycle(1'b1);
        checks++;
        if (timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clear: after arming rise timeout %0b, want 0", timeout);
        end
        repeat (6) drive_cycle(1'b0);
        wave(6, 6, 2);
        checks++;
        if (sb.size() != 0 || period !== CW'(12)) begin
            errors++;
            $display("FAIL restart_measure: got pending %0d period %0d, want 0 12", sb.size(), period);
        end
    endtask

    task automatic test_reset_mid();
        wave(6, 6, 4);
        drive_cycle(1'b1);
        repeat (3) drive_cycle(1'b0);
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL lock_before_reset: got locked %0b, want 1", locked);
        end
        reset     = 1'b1;
        clk_sense = 1'b0;
        @(negedge clock_in);
        checks++;
        if ({period, high_time, valid, locked, timeout} !== '0) begin
            errors++;
            $display("FAIL reset_mid: got period %0d high_time %0d valid %0b locked %0b timeout %0b, want all 0",
                     period, high_time, valid, locked, timeout);
        end
        reset = 1'b0;
        model_reset();
        wave(6, 6, 3);
        checks++;
        if (period !== CW'(12) || high_time !== CW'(6) || locked !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_measure: got period %0d high_time %0d locked %0b, want 12 6 0",
                     period, high_time, locked);
        end
    endtask

    initial begin
        test_reset();
        test_div2();
        test_div10();
        test_duty();
        test_period_change();
        test_timeout();
        test_reset_mid();
        repeat (4) @(negedge clock_in);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL leftover_expectations: got %0d pending, want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
